qcore_ctrl_pipe: RTL and testbench
==================================

Name: qcore_ctrl_pipe

Overview:
- Control-field pipeline that carries each decoded instruction's write-back control through the RD, X1, X2 and WR stages.
- It feeds the hazard/forwarding unit with per-stage write-enable, destination address, data source, wave-register write, port-read and flag-write fields.
- It consumes that unit's bubble requests and applies them: it holds the upstream stages and inserts NOPs.
- It also applies jump flushes and core halt, and keeps a saturating stall counter for debug.

Parameters:
- ADDR_W, 7, destination register address width (bits [6:5] select the register bank).
- SRC_W, 2, write-back data source code: 00 ALU, 01 DMEM, 11 IMM.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous active-high reset
- halt_i  in  1  freeze every stage register and the counter
- id_valid_i  in  1  ID holds a real instruction
- id_we_i  in  1  instruction writes a register
- id_addr_i  in  ADDR_W  destination address
- id_src_i  in  SRC_W  write-back source
- id_wave_we_i  in  1  writes r_wave
- id_port_re_i  in  1  reads data port
- id_flag_we_i  in  1  updates flag
- bubble_id_i  in  1  hold ID, insert NOP into RD
- bubble_rd_i  in  1  hold ID and RD, insert NOP into X1
- flush_i  in  1  jump taken in X1; kill the ID and RD contents
- {rd,x1,x2,wr}_we_o  out  1 each  valid-gated write enable
- {rd,x1,x2,wr}_addr_o  out  ADDR_W each
- {rd,x1,x2,wr}_src_o  out  SRC_W each
- {rd,x1,x2}_wave_we_o  out  1 each
- {rd,x1,x2}_port_re_o  out  1 each
- flag_we_o  out  1  OR of the flag_we fields of the valid RD, X1 and X2 stages
- id_en_o  out  1  ID/fetch may advance
- rd_en_o  out  1  RD register-read stage may advance
- stall_cnt_o  out  CNT_W  cycles lost to bubbles
- clr_cnt_i  in  1  synchronous clear of stall_cnt_o

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits 0, all fields 0, stall_cnt_o = 0. Consequently all *_we_o, *_wave_we_o, *_port_re_o and flag_we_o read 0 during reset.
- Reset mid-operation discards in-flight instructions. No write enable may assert until an instruction has been accepted after reset release.
- Each stage holds {valid, we, addr, src, wave_we, port_re, flag_we}.
- Output fields are gated: *_we_o = valid & we, and likewise for wave_we, port_re and flag_we. addr_o and src_o pass through ungated.
- Normal advance with no halt, flush or bubble, one cycle per stage: RD <= ID inputs, X1 <= RD, X2 <= X1, WR <= X2. An ID instruction therefore reaches WR 4 edges after acceptance.
- Per-edge priority: halt_i > flush_i > bubble_rd_i > bubble_id_i.
- halt_i = 1:
  - No register changes, counter included.
  - id_en_o = rd_en_o = 0.
- flush_i = 1:
  - RD <= NOP and X1 <= NOP, killing the instructions in ID and RD.
  - X2 <= X1 and WR <= X2.
  - id_en_o = 1 and rd_en_o = 1, so fetch refills.
  - Any bubbles in the same cycle are ignored.
  - Counter is not incremented.
- bubble_rd_i = 1:
  - RD holds its contents, X1 <= NOP, X2 <= X1, WR <= X2.
  - id_en_o = 0 and rd_en_o = 0.
- bubble_id_i = 1 only:
  - RD <= NOP, X1 <= RD, X2 <= X1, WR <= X2.
  - id_en_o = 0 and rd_en_o = 1.
- With no bubble, id_en_o = rd_en_o = 1 (outside halt).
- id_en_o and rd_en_o are combinational from the current inputs. The upstream fetch and the RD register bank use them as clock enables in the same cycle.
- id_valid_i = 0 is accepted as a NOP; its field inputs are don't-care and its outputs are gated to 0.
- stall_cnt_o:
  - Increments by 1 on each edge where (bubble_id_i | bubble_rd_i) & ~halt_i & ~flush_i.
  - Saturates at all-ones and does not wrap.
  - clr_cnt_i forces 0 and has priority over increment, but not over halt.
- flag_we_o and the stage outputs are pure decodes of registered state, with no combinational path from the bubble inputs.

Test Plan:
- Straight-line pass: issue A (we=1, addr=0x05, src=00) then B (addr=0x4F, src=11) → A's we/addr appear at rd, x1, x2, wr on edges 1..4. B follows one cycle behind. id_en_o stays 1 throughout.
- bubble_id for 1 cycle with A in RD → next cycle x1 shows A and rd_we_o = 0. The ID instruction enters RD one cycle late. stall_cnt_o = 1.
- bubble_rd for 2 cycles with A in RD → A stays in RD for 3 cycles. X1 gets 2 NOPs. id_en_o = rd_en_o = 0 during the bubbles. stall_cnt_o = 2.
- flush_i with A in RD, B in ID and bubble_rd_i = 1 simultaneously → next cycle rd_we_o = x1_we_o = 0. Older X1 content moves to X2. stall_cnt_o is unchanged.
- halt_i for 3 cycles mid-stream with bubble_id_i = 1 → all outputs frozen and counter frozen. The stream resumes unaltered after halt drops.
- Saturation and reset: preload 0xFFFF, apply a bubble → counter stays 0xFFFF. Assert rst_i asynchronously between edges → all *_we_o and flag_we_o drop to 0 immediately and stall_cnt_o = 0.

Source files
------------

// File: rtl/qcore_ctrl_pipe.sv
// rtl/qcore_ctrl_pipe.sv - write-back control pipeline RD->X1->X2->WR with bubbles, flush, halt
// Carries per-instruction write-back control fields and a saturating stall counter.
module qcore_ctrl_pipe #(
    parameter int ADDR_W = 7,
    parameter int SRC_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              halt_i,
    input  logic              id_valid_i,
    input  logic              id_we_i,
    input  logic [ADDR_W-1:0] id_addr_i,
    input  logic [SRC_W-1:0]  id_src_i,
    input  logic              id_wave_we_i,
    input  logic              id_port_re_i,
    input  logic              id_flag_we_i,
    input  logic              bubble_id_i,
    input  logic              bubble_rd_i,
    input  logic              flush_i,
    input  logic              clr_cnt_i,
    output logic              rd_we_o,
    output logic              x1_we_o,
    output logic              x2_we_o,
    output logic              wr_we_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] x1_addr_o,
    output logic [ADDR_W-1:0] x2_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [SRC_W-1:0]  rd_src_o,
    output logic [SRC_W-1:0]  x1_src_o,
    output logic [SRC_W-1:0]  x2_src_o,
    output logic [SRC_W-1:0]  wr_src_o,
    output logic              rd_wave_we_o,
    output logic              x1_wave_we_o,
    output logic              x2_wave_we_o,
    output logic              rd_port_re_o,
    output logic              x1_port_re_o,
    output logic              x2_port_re_o,
    output logic              flag_we_o,
    output logic              id_en_o,
    output logic              rd_en_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [SRC_W-1:0]  src;
        logic              wave_we;
        logic              port_re;
        logic              flag_we;
    } stage_t;

    stage_t            w_id;
    stage_t            r_rd, r_x1, r_x2;
    logic              r_wr_valid, r_wr_we;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [SRC_W-1:0]  r_wr_src;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_bubble;

    assign w_id = '{valid: id_valid_i, we: id_we_i, addr: id_addr_i, src: id_src_i,
                    wave_we: id_wave_we_i, port_re: id_port_re_i, flag_we: id_flag_we_i};

    // A flush overrides any bubble raised in the same cycle.
    assign w_bubble = (bubble_id_i | bubble_rd_i) & ~flush_i;
    assign id_en_o  = ~halt_i & ~w_bubble;
    assign rd_en_o  = ~halt_i & (flush_i | ~bubble_rd_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd       <= '0;
            r_x1       <= '0;
            r_x2       <= '0;
            r_wr_valid <= 1'b0;
            r_wr_we    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_src   <= '0;
        end else if (!halt_i) begin
            r_wr_valid <= r_x2.valid;
            r_wr_we    <= r_x2.we;
            r_wr_addr  <= r_x2.addr;
            r_wr_src   <= r_x2.src;
            r_x2       <= r_x1;
            if (flush_i) begin
                r_x1 <= '0;
                r_rd <= '0;
            end else if (bubble_rd_i) begin
                r_x1 <= '0;
            end else if (bubble_id_i) begin
                r_x1 <= r_rd;
                r_rd <= '0;
            end else begin
                r_x1 <= r_rd;
                r_rd <= w_id;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (!halt_i) begin
            if (clr_cnt_i) begin
                r_stall_cnt <= '0;
            end else if (w_bubble && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign rd_we_o      = r_rd.valid & r_rd.we;
    assign x1_we_o      = r_x1.valid & r_x1.we;
    assign x2_we_o      = r_x2.valid & r_x2.we;
    assign wr_we_o      = r_wr_valid & r_wr_we;
    assign rd_addr_o    = r_rd.addr;
    assign x1_addr_o    = r_x1.addr;
    assign x2_addr_o    = r_x2.addr;
    assign wr_addr_o    = r_wr_addr;
    assign rd_src_o     = r_rd.src;
    assign x1_src_o     = r_x1.src;
    assign x2_src_o     = r_x2.src;
    assign wr_src_o     = r_wr_src;
    assign rd_wave_we_o = r_rd.valid & r_rd.wave_we;
    assign x1_wave_we_o = r_x1.valid & r_x1.wave_we;
    assign x2_wave_we_o = r_x2.valid & r_x2.wave_we;
    assign rd_port_re_o = r_rd.valid & r_rd.port_re;
    assign x1_port_re_o = r_x1.valid & r_x1.port_re;
    assign x2_port_re_o = r_x2.valid & r_x2.port_re;
    assign flag_we_o    = (r_rd.valid & r_rd.flag_we) | (r_x1.valid & r_x1.flag_we)
                        | (r_x2.valid & r_x2.flag_we);
    assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_qcore_ctrl_pipe.sv
// tb/tb_qcore_ctrl_pipe.sv - scoreboard bench for qcore_ctrl_pipe
// Driver pushes model predictions into a queue; a negedge monitor pops and compares.
module tb_qcore_ctrl_pipe;
    localparam int AW   = 7;
    localparam int SW   = 2;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, halt = 1'b0, id_valid = 1'b0, id_we = 1'b0;
    logic [AW-1:0] id_addr = '0;
    logic [SW-1:0] id_src = '0;
    logic          id_wave = 1'b0, id_port = 1'b0, id_flag = 1'b0;
    logic          bub_id = 1'b0, bub_rd = 1'b0, flush = 1'b0, clr = 1'b0;
    logic          rd_we, x1_we, x2_we, wr_we;
    logic [AW-1:0] rd_addr, x1_addr, x2_addr, wr_addr;
    logic [SW-1:0] rd_src, x1_src, x2_src, wr_src;
    logic          rd_wave, x1_wave, x2_wave, rd_port, x1_port, x2_port;
    logic          flag_we, id_en, rd_en;
    logic [CW-1:0] stall_cnt;

    qcore_ctrl_pipe #(.ADDR_W(AW), .SRC_W(SW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .halt_i(halt),
        .id_valid_i(id_valid), .id_we_i(id_we), .id_addr_i(id_addr), .id_src_i(id_src),
        .id_wave_we_i(id_wave), .id_port_re_i(id_port), .id_flag_we_i(id_flag),
        .bubble_id_i(bub_id), .bubble_rd_i(bub_rd), .flush_i(flush), .clr_cnt_i(clr),
        .rd_we_o(rd_we), .x1_we_o(x1_we), .x2_we_o(x2_we), .wr_we_o(wr_we),
        .rd_addr_o(rd_addr), .x1_addr_o(x1_addr), .x2_addr_o(x2_addr), .wr_addr_o(wr_addr),
        .rd_src_o(rd_src), .x1_src_o(x1_src), .x2_src_o(x2_src), .wr_src_o(wr_src),
        .rd_wave_we_o(rd_wave), .x1_wave_we_o(x1_wave), .x2_wave_we_o(x2_wave),
        .rd_port_re_o(rd_port), .x1_port_re_o(x1_port), .x2_port_re_o(x2_port),
        .flag_we_o(flag_we), .id_en_o(id_en), .rd_en_o(rd_en), .stall_cnt_o(stall_cnt)
    );

    // Index 0 = RD, 1 = X1, 2 = X2, 3 = WR.
    logic [3:0]         a_we;
    logic [3:0][AW-1:0] a_addr;
    logic [3:0][SW-1:0] a_src;
    logic [2:0]         a_wave, a_port;
    assign a_we   = {wr_we, x2_we, x1_we, rd_we};
    assign a_addr = {wr_addr, x2_addr, x1_addr, rd_addr};
    assign a_src  = {wr_src, x2_src, x1_src, rd_src};
    assign a_wave = {x2_wave, x1_wave, rd_wave};
    assign a_port = {x2_port, x1_port, rd_port};

    typedef struct {
        bit v, we;
        int addr, src;
        bit wave, port, flag;
    } ins_t;

    typedef struct packed {
        logic [3:0]         vld, we;
        logic [3:0][AW-1:0] addr;
        logic [3:0][SW-1:0] src;
        logic [2:0]         wave, port;
        logic               flag, id_en, rd_en;
        logic [CW-1:0]      cnt;
    } exp_t;

    ins_t pipe[4];
    int   cnt = 0;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic void chk(string nm, int idx, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t got %0h expected %0h", nm, idx, $time, act, exp);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < 4; i++) begin
                    chk("we", i, int'(a_we[i]), int'(e.we[i]));
                    if (e.vld[i]) begin
                        chk("addr", i, int'(a_addr[i]), int'(e.addr[i]));
                        chk("src", i, int'(a_src[i]), int'(e.src[i]));
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    chk("wave_we", i, int'(a_wave[i]), int'(e.wave[i]));
                    chk("port_re", i, int'(a_port[i]), int'(e.port[i]));
                end
                chk("flag_we", 0, int'(flag_we), int'(e.flag));
                chk("id_en", 0, int'(id_en), int'(e.id_en));
                chk("rd_en", 0, int'(rd_en), int'(e.rd_en));
                chk("stall_cnt", 0, int'(stall_cnt), int'(e.cnt));
            end
        end
    end

    // One cycle of stimulus: drive after the edge, predict what the monitor will see
    // this cycle, then advance the model to what the next edge should produce.
    task automatic step(input bit v, input bit we, input int addr, input int src,
                        input bit wv, input bit pt, input bit fl,
                        input bit bid, input bit brd, input bit flu, input bit hlt,
                        input bit cl, input bit rs);
        exp_t e;
        ins_t nop, idi;
        ins_t nx[4];
        bit   stalled;
        @(posedge clk);
        #1;
        id_valid = v; id_we = we; id_addr = addr[AW-1:0]; id_src = src[SW-1:0];
        id_wave = wv; id_port = pt; id_flag = fl;
        bub_id = bid; bub_rd = brd; flush = flu; halt = hlt; clr = cl; rst = rs;
        nop = '{default: 0};
        if (rs) begin
            for (int i = 0; i < 4; i++) pipe[i] = nop;
            cnt = 0;
        end
        e = '0;
        for (int i = 0; i < 4; i++) begin
            e.vld[i]  = pipe[i].v;
            e.we[i]   = pipe[i].v && pipe[i].we;
            e.addr[i] = pipe[i].addr[AW-1:0];
            e.src[i]  = pipe[i].src[SW-1:0];
            if (i < 3) begin
                e.wave[i] = pipe[i].v && pipe[i].wave;
                e.port[i] = pipe[i].v && pipe[i].port;
                if (pipe[i].v && pipe[i].flag) e.flag = 1'b1;
            end
        end
        stalled = (bid || brd) && !flu;
        e.id_en = !hlt && !stalled;
        e.rd_en = !hlt && (flu || !brd);
        e.cnt   = cnt[CW-1:0];
        exp_q.push_back(e);
        if (!rs && !hlt) begin
            idi = '{v: v, we: we, addr: addr, src: src, wave: wv, port: pt, flag: fl};
            nx[3] = pipe[2];
            nx[2] = pipe[1];
            if (flu) begin
                nx[1] = nop; nx[0] = nop;
            end else if (brd) begin
                nx[1] = nop; nx[0] = pipe[0];
            end else if (bid) begin
                nx[1] = pipe[0]; nx[0] = nop;
            end else begin
                nx[1] = pipe[0]; nx[0] = idi;
            end
            pipe = nx;
            if (cl) cnt = 0;
            else if (stalled && cnt < MAXC) cnt++;
        end
    endtask

    task automatic ins(input bit we, input int addr, input int src,
                       input bit bid, input bit brd, input bit flu, input bit hlt);
        step(1, we, addr, src, 1'b1, 1'b0, 1'b1, bid, brd, flu, hlt, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pipe[i] = '{default: 0};
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // straight-line A then B
        ins(1, 'h05, 0, 0, 0, 0, 0);
        ins(1, 'h4F, 3, 0, 0, 0, 0);
        idle(5);
        // bubble_id with A in RD
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        ins(1, 'h05, 0, 0, 0, 0, 0);
        ins(1, 'h4F, 3, 1, 0, 0, 0);
        ins(1, 'h4F, 3, 0, 0, 0, 0);
        idle(5);
        // bubble_rd for two cycles
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        ins(1, 'h05, 0, 0, 0, 0, 0);
        ins(1, 'h4F, 3, 0, 1, 0, 0);
        ins(1, 'h4F, 3, 0, 1, 0, 0);
        ins(1, 'h4F, 3, 0, 0, 0, 0);
        idle(5);
        // flush with simultaneous bubble_rd
        ins(1, 'h21, 1, 0, 0, 0, 0);
        ins(1, 'h05, 0, 0, 0, 0, 0);
        ins(1, 'h4F, 3, 0, 1, 1, 0);
        idle(5);
        // halt for three cycles with bubble_id held
        ins(1, 'h05, 0, 0, 0, 0, 0);
        ins(1, 'h4F, 3, 0, 0, 0, 0);
        ins(1, 'h33, 1, 1, 0, 0, 1);
        ins(1, 'h33, 1, 1, 0, 0, 1);
        ins(1, 'h33, 1, 1, 0, 0, 1);
        ins(1, 'h33, 1, 0, 0, 0, 0);
        idle(5);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 127)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
        end
        // saturation: drive the counter to all-ones and beyond
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int n = 0; n < MAXC + 5; n++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // asynchronous reset with instructions in flight
        ins(1, 'h05, 0, 0, 0, 0, 0);
        ins(1, 'h4F, 3, 0, 0, 0, 0);
        ins(1, 'h11, 1, 0, 0, 0, 0);
        step(1, 1, 'h22, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 'h22, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        idle(2);
        ins(1, 'h7E, 2, 0, 0, 0, 0);
        idle(5);
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain queue_left=%0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
